// File: rtl/hx711_responder.sv
// HX711 serial responder: emits 24-bit samples on dout under host PD_SCK, decodes 25/26/27-pulse gain, emulates power-down.
// Latency: dout reacts 3 clocks after sclk_in rises; no backpressure, a read in progress waits indefinitely for the host.
module hx711_responder #(
  parameter int CONV_PERIOD_CYCLES = 1000,
  parameter int PD_TIMEOUT_CYCLES  = 6000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sclk_in,
  input  logic [23:0] sample_in,
  input  logic        sample_valid,
  output logic        dout,
  output logic        data_ready,
  output logic [1:0]  gain_sel,
  output logic        conv_done,
  output logic        read_done,
  output logic        pd_active
);

  localparam int CW = (CONV_PERIOD_CYCLES > 1) ? $clog2(CONV_PERIOD_CYCLES) : 1;
  localparam int PW = (PD_TIMEOUT_CYCLES > 1) ? $clog2(PD_TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_PERIOD_CYCLES - 1);
  localparam logic [PW-1:0] PD_LAST   = PW'(PD_TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_CONVERT = 2'd0;
  localparam logic [1:0] ST_READY   = 2'd1;
  localparam logic [1:0] ST_SHIFT   = 2'd2;
  localparam logic [1:0] ST_PWRDN   = 2'd3;

  logic [1:0]    state;
  logic          s1, s2, s3;
  logic [CW-1:0] conv_timer;
  logic [PW-1:0] pd_timer;
  logic [23:0]   holding;
  logic [23:0]   shift;
  logic [4:0]    bit_cnt;
  logic [1:0]    pulse_cnt;

  logic        rise, fall, expire, pd_hit;
  logic [23:0] next_word;

  assign rise       = s2 & ~s3;
  assign fall       = ~s2 & s3;
  assign expire     = (conv_timer == CONV_LAST);
  assign pd_hit     = s2 && (pd_timer == PD_LAST) && (state != ST_PWRDN);
  // A sample arriving on the expiry cycle goes straight into the shift register.
  assign next_word  = sample_valid ? sample_in : holding;
  assign data_ready = (state == ST_READY);
  assign pd_active  = (state == ST_PWRDN);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_CONVERT;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      conv_timer <= '0;
      pd_timer   <= '0;
      holding    <= '0;
      shift      <= '0;
      bit_cnt    <= '0;
      pulse_cnt  <= '0;
      dout       <= 1'b1;
      gain_sel   <= 2'b00;
      conv_done  <= 1'b0;
      read_done  <= 1'b0;
    end else begin
      s1        <= sclk_in;
      s2        <= s1;
      s3        <= s2;
      conv_done <= 1'b0;
      read_done <= 1'b0;

      if (sample_valid) holding <= sample_in;

      if (state == ST_PWRDN || !s2) pd_timer <= '0;
      else if (!pd_hit)             pd_timer <= pd_timer + PW'(1);

      if (pd_hit) begin
        state     <= ST_PWRDN;
        dout      <= 1'b1;
        bit_cnt   <= '0;
        pulse_cnt <= '0;
      end else begin
        case (state)
          ST_CONVERT: begin
            dout <= 1'b1;
            if (expire) begin
              conv_timer <= '0;
              conv_done  <= 1'b1;
              pulse_cnt  <= '0;
              shift      <= next_word;
              dout       <= 1'b0;
              state      <= ST_READY;
              case (pulse_cnt)
                2'd1:    gain_sel <= 2'b00;
                2'd2:    gain_sel <= 2'b01;
                2'd3:    gain_sel <= 2'b10;
                default: gain_sel <= gain_sel;
              endcase
            end else begin
              conv_timer <= conv_timer + CW'(1);
              if (rise && pulse_cnt != 2'd3) pulse_cnt <= pulse_cnt + 2'd1;
            end
          end
          ST_READY: begin
            if (rise) begin
              dout    <= shift[23];
              shift   <= {shift[22:0], 1'b0};
              bit_cnt <= 5'd1;
              state   <= ST_SHIFT;
            end else begin
              dout <= 1'b0;
              if (expire) begin
                conv_timer <= '0;
                shift      <= next_word;
                conv_done  <= 1'b1;
              end else begin
                conv_timer <= conv_timer + CW'(1);
              end
            end
          end
          ST_SHIFT: begin
            if (rise) begin
              if (bit_cnt < 5'd24) begin
                dout    <= shift[23];
                shift   <= {shift[22:0], 1'b0};
                bit_cnt <= bit_cnt + 5'd1;
              end else begin
                // 25th pulse closes the word; later pulses select gain for the next conversion.
                dout       <= 1'b1;
                read_done  <= 1'b1;
                pulse_cnt  <= 2'd1;
                conv_timer <= '0;
                bit_cnt    <= '0;
                state      <= ST_CONVERT;
              end
            end
          end
          ST_PWRDN: begin
            dout <= 1'b1;
            if (fall) begin
              state      <= ST_CONVERT;
              conv_timer <= '0;
              gain_sel   <= 2'b00;
            end
          end
          default: state <= ST_CONVERT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hx711_responder.sv
// Directed bench for hx711_responder: host-side PD_SCK driver with hand-computed expected words, gains and timings.
module tb_hx711_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        sclk_in;
  logic [23:0] sample_in;
  logic        sample_valid;
  logic        dout;
  logic        data_ready;
  logic [1:0]  gain_sel;
  logic        conv_done;
  logic        read_done;
  logic        pd_active;

  int checks = 0;
  int errors = 0;
  int rd_count = 0;

  hx711_responder #(
    .CONV_PERIOD_CYCLES(1000),
    .PD_TIMEOUT_CYCLES (6000)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sclk_in     (sclk_in),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .dout        (dout),
    .data_ready  (data_ready),
    .gain_sel    (gain_sel),
    .conv_done   (conv_done),
    .read_done   (read_done),
    .pd_active   (pd_active)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (read_done) rd_count++;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_sample(input logic [23:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    step(1);
    sample_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < 2000) begin
      step(1);
      n++;
      if (dout == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_conv_done(output int n, output bit ok, output bit saw_high);
    n        = 0;
    ok       = 1'b0;
    saw_high = 1'b0;
    while (n < 2000) begin
      step(1);
      n++;
      if (dout == 1'b1) saw_high = 1'b1;
      if (conv_done == 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Host clocking: 50 cycles high, 50 low; dout sampled at the end of each high phase.
  task automatic read_bits(input int npulses, output logic [23:0] word);
    word = '0;
    for (int i = 0; i < npulses; i++) begin
      sclk_in = 1'b1;
      step(50);
      if (i < 24) word = {word[22:0], dout};
      sclk_in = 1'b0;
      step(50);
    end
  endtask

  task automatic read_word(input int npulses, input logic [23:0] exp_word);
    logic [23:0] word;
    int rd0;
    rd0  = rd_count;
    word = '0;
    for (int i = 0; i < npulses; i++) begin
      sclk_in = 1'b1;
      step(50);
      if (i < 24) word = {word[22:0], dout};
      if (i == 23) check("read_done_early", rd_count - rd0, 0);
      if (i == 24) begin
        check("read_done_25th", rd_count - rd0, 1);
        check("dout_after_25th", {31'd0, dout}, 1);
        check("word", {8'd0, word}, {8'd0, exp_word});
      end
      sclk_in = 1'b0;
      step(50);
    end
  endtask

  task automatic gain_test(input int npulses, input logic [23:0] exp_word, input logic [1:0] exp_gain);
    int  n;
    bit  ok;
    read_word(npulses, exp_word);
    wait_ready(n, ok);
    check("gain_ready_seen", {31'd0, ok}, 1);
    check("gain_sel", {30'd0, gain_sel}, {30'd0, exp_gain});
  endtask

  initial begin
    int          n;
    int          m;
    bit          ok;
    bit          saw_high;
    logic [23:0] w;

    reset        = 1'b1;
    sclk_in      = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    step(3);
    check("rst_dout", {31'd0, dout}, 1);
    check("rst_data_ready", {31'd0, data_ready}, 0);
    check("rst_gain", {30'd0, gain_sel}, 0);
    check("rst_conv_done", {31'd0, conv_done}, 0);
    check("rst_read_done", {31'd0, read_done}, 0);
    check("rst_pd_active", {31'd0, pd_active}, 0);

    // First conversion: dout high for the full period, then ready with 0x800001.
    reset = 1'b0;
    pulse_sample(24'h800001);
    wait_ready(n, ok);
    check("first_ready_cycles", 1 + n, 1000);
    check("first_conv_done", {31'd0, conv_done}, 1);
    check("first_data_ready", {31'd0, data_ready}, 1);
    gain_test(25, 24'h800001, 2'b00);
    gain_test(26, 24'h800001, 2'b01);
    gain_test(27, 24'h800001, 2'b10);

    // Power-down mid-word, then recovery to gain A/128.
    read_bits(10, w);
    check("pd_first_bits", {22'd0, w[9:0]}, 32'h200);
    sclk_in = 1'b1;
    n = 0;
    while (n < 7000) begin
      step(1);
      n++;
      if (pd_active) break;
    end
    check("pd_entry_cycles", n, 6002);
    check("pd_dout", {31'd0, dout}, 1);
    sclk_in = 1'b0;
    m = 0;
    while (m < 20) begin
      step(1);
      m++;
      if (!pd_active) break;
    end
    check("pd_exit_cycles", m, 3);
    check("pd_exit_gain", {30'd0, gain_sel}, 0);
    wait_ready(n, ok);
    check("pd_ready_cycles", n, 1000);
    gain_test(25, 24'h800001, 2'b00);
    gain_test(30, 24'h800001, 2'b10);
    gain_test(25, 24'h800001, 2'b00);

    // Two unread conversions: dout stays low, the latest sample wins.
    pulse_sample(24'h000123);
    wait_conv_done(n, ok, saw_high);
    check("noread1_seen", {31'd0, ok}, 1);
    check("noread1_period", 1 + n, 1000);
    check("noread1_dout_low", {31'd0, saw_high}, 0);
    pulse_sample(24'h7FFFFF);
    wait_conv_done(n, ok, saw_high);
    check("noread2_seen", {31'd0, ok}, 1);
    check("noread2_period", 1 + n, 1000);
    check("noread2_dout_low", {31'd0, saw_high}, 0);
    read_word(25, 24'h7FFFFF);
    wait_ready(n, ok);
    check("bypass_pre_ready", {31'd0, ok}, 1);

    // Sample strobe landing exactly on the expiry bypasses the holding register.
    pulse_sample(24'h111111);
    step(998);
    sample_in    = 24'h0ABCDE;
    sample_valid = 1'b1;
    step(1);
    sample_valid = 1'b0;
    check("bypass_coincide", {31'd0, conv_done}, 1);
    gain_test(26, 24'h0ABCDE, 2'b01);

    // Reset in the middle of a word.
    read_bits(12, w);
    reset = 1'b1;
    step(1);
    check("midrst_dout", {31'd0, dout}, 1);
    check("midrst_pd_active", {31'd0, pd_active}, 0);
    check("midrst_gain", {30'd0, gain_sel}, 0);
    check("midrst_data_ready", {31'd0, data_ready}, 0);
    reset = 1'b0;
    wait_ready(n, ok);
    check("midrst_ready_cycles", n, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
